// File: rtl/rv_go_hazard_ctrl.sv
// rv_go hazard controller: hazard detection, forwarding select,
// load-use interlock, redirect flush and saturating stall/flush counters.
module rv_go_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_w,
    input  logic              id_mem_to_reg,
    input  logic              ex_redirect,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_id,
    output logic              bubble_ex,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              id_bypass_a,
    output logic              id_bypass_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_w;
        logic              mem_to_reg;
    } stg_t;

    stg_t              e_q, m_q, w_q;
    logic [REG_AW-1:0] e_rs1, e_rs2;
    logic              e_use1, e_use2;
    logic              dep, stall;

    // A writer targeting x0 never matches any reader.
    function automatic logic match(stg_t s, logic [REG_AW-1:0] r,
                                   logic use_r);
        return s.valid & s.reg_w & (s.rd != '0) & (s.rd == r) & use_r;
    endfunction

    function automatic logic [1:0] fwd_sel(stg_t m, stg_t w,
                                           logic [REG_AW-1:0] r,
                                           logic use_r);
        if (match(m, r, use_r) && !m.mem_to_reg) return 2'b01;
        if (match(w, r, use_r)) return 2'b10;
        return 2'b00;
    endfunction

    generate
        if (FWD_EN != 0) begin : g_fwd
            always_comb begin
                dep = id_valid & e_q.valid & e_q.mem_to_reg &
                      (match(e_q, id_rs1, id_use_rs1) |
                       match(e_q, id_rs2, id_use_rs2));
                fwd_a_sel = fwd_sel(m_q, w_q, e_rs1, e_use1);
                fwd_b_sel = fwd_sel(m_q, w_q, e_rs2, e_use2);
            end
        end else begin : g_stall
            always_comb begin
                dep = id_valid &
                      (match(e_q, id_rs1, id_use_rs1) |
                       match(m_q, id_rs1, id_use_rs1) |
                       match(e_q, id_rs2, id_use_rs2) |
                       match(m_q, id_rs2, id_use_rs2));
                fwd_a_sel = 2'b00;
                fwd_b_sel = 2'b00;
            end
        end
    endgenerate

    // Redirect wins: the stalled D instruction is on the wrong path anyway.
    assign stall       = dep & ~ex_redirect;
    assign stall_if    = stall;
    assign stall_id    = stall;
    assign flush_id    = ex_redirect;
    assign bubble_ex   = stall | ex_redirect;
    assign id_bypass_a = id_valid & match(w_q, id_rs1, id_use_rs1);
    assign id_bypass_b = id_valid & match(w_q, id_rs2, id_use_rs2);

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q    <= '0;
            m_q    <= '0;
            w_q    <= '0;
            e_rs1  <= '0;
            e_rs2  <= '0;
            e_use1 <= 1'b0;
            e_use2 <= 1'b0;
        end else begin
            w_q <= m_q;
            m_q <= e_q;
            if (bubble_ex || !id_valid) begin
                e_q    <= '0;
                e_rs1  <= '0;
                e_rs2  <= '0;
                e_use1 <= 1'b0;
                e_use2 <= 1'b0;
            end else begin
                e_q    <= '{1'b1, id_rd, id_reg_w, id_mem_to_reg};
                e_rs1  <= id_rs1;
                e_rs2  <= id_rs2;
                e_use1 <= id_use_rs1;
                e_use2 <= id_use_rs2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_id && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (ex_redirect && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rv_go_hazard_ctrl.sv
// Directed bench for rv_go_hazard_ctrl: forwarding mode, stall-only mode
// and a narrow-counter instance, all driven from one shared stimulus.
module tb_rv_go_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2, id_reg_w, id_mem_to_reg;
    logic       ex_redirect;

    logic        f_sif, f_sid, f_fl, f_bub, f_bpa, f_bpb;
    logic [1:0]  f_fa, f_fb;
    logic [31:0] f_scnt, f_fcnt;

    logic        s_sif, s_sid, s_fl, s_bub, s_bpa, s_bpb;
    logic [1:0]  s_fa, s_fb;
    logic [31:0] s_scnt, s_fcnt;

    logic        t_sif, t_sid, t_fl, t_bub, t_bpa, t_bpb;
    logic [1:0]  t_fa, t_fb;
    logic [1:0]  t_scnt, t_fcnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rv_go_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .CNT_W(32)) u_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_w(id_reg_w), .id_mem_to_reg(id_mem_to_reg),
        .ex_redirect(ex_redirect),
        .stall_if(f_sif), .stall_id(f_sid), .flush_id(f_fl),
        .bubble_ex(f_bub), .fwd_a_sel(f_fa), .fwd_b_sel(f_fb),
        .id_bypass_a(f_bpa), .id_bypass_b(f_bpb),
        .stall_cnt(f_scnt), .flush_cnt(f_fcnt)
    );

    rv_go_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .CNT_W(32)) u_stl (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_w(id_reg_w), .id_mem_to_reg(id_mem_to_reg),
        .ex_redirect(ex_redirect),
        .stall_if(s_sif), .stall_id(s_sid), .flush_id(s_fl),
        .bubble_ex(s_bub), .fwd_a_sel(s_fa), .fwd_b_sel(s_fb),
        .id_bypass_a(s_bpa), .id_bypass_b(s_bpb),
        .stall_cnt(s_scnt), .flush_cnt(s_fcnt)
    );

    rv_go_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_w(id_reg_w), .id_mem_to_reg(id_mem_to_reg),
        .ex_redirect(ex_redirect),
        .stall_if(t_sif), .stall_id(t_sid), .flush_id(t_fl),
        .bubble_ex(t_bub), .fwd_a_sel(t_fa), .fwd_b_sel(t_fb),
        .id_bypass_a(t_bpa), .id_bypass_b(t_bpb),
        .stall_cnt(t_scnt), .flush_cnt(t_fcnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1,
                         input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd,
                         input logic w, input logic ld);
        id_valid      = v;
        id_rs1        = rs1;
        id_use_rs1    = u1;
        id_rs2        = rs2;
        id_use_rs2    = u2;
        id_rd         = rd;
        id_reg_w      = w;
        id_mem_to_reg = ld;
        #1;
    endtask

    task automatic do_reset();
        ex_redirect = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({f_sif, f_sid, f_fl, f_bub, f_fa, f_fb, f_bpa, f_bpb} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b want=0",
                     {f_sif, f_sid, f_fl, f_bub, f_fa, f_fb, f_bpa, f_bpb});
        end
        checks++;
        if (f_scnt !== 32'd0 || f_fcnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt got=%0d/%0d want=0/0", f_scnt, f_fcnt);
        end
    endtask

    task automatic test_alu_chain();
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd10, 1'b1, 1'b0);
        checks++;
        if (f_sid !== 1'b0 || f_bub !== 1'b0) begin
            errors++;
            $display("FAIL alu_nostall got=%b%b want=00", f_sid, f_bub);
        end
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd11, 1'b1, 1'b0);
        checks++;
        if (f_fa !== 2'b01 || f_fb !== 2'b00) begin
            errors++;
            $display("FAIL alu_fwd_m got=%b/%b want=01/00", f_fa, f_fb);
        end
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 5'd12, 1'b1, 1'b0);
        checks++;
        if (f_fa !== 2'b10) begin
            errors++;
            $display("FAIL alu_fwd_w got=%b want=10", f_fa);
        end
        checks++;
        if (f_bpa !== 1'b1 || f_bpb !== 1'b0) begin
            errors++;
            $display("FAIL alu_bypass got=%b%b want=10", f_bpa, f_bpb);
        end
        checks++;
        if (f_scnt !== 32'd0) begin
            errors++;
            $display("FAIL alu_scnt got=%0d want=0", f_scnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd6, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0);
        checks++;
        if ({f_sif, f_sid, f_bub, f_fl} !== 4'b1110) begin
            errors++;
            $display("FAIL lu_stall got=%b want=1110",
                     {f_sif, f_sid, f_bub, f_fl});
        end
        tick();
        checks++;
        if ({f_sif, f_sid, f_bub, f_fa} !== 5'b00000) begin
            errors++;
            $display("FAIL lu_release got=%b want=00000",
                     {f_sif, f_sid, f_bub, f_fa});
        end
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (f_fa !== 2'b10 || f_fb !== 2'b00) begin
            errors++;
            $display("FAIL lu_fwd got=%b/%b want=10/00", f_fa, f_fb);
        end
        checks++;
        if (f_scnt !== 32'd1) begin
            errors++;
            $display("FAIL lu_scnt got=%0d want=1", f_scnt);
        end
    endtask

    task automatic test_x0();
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
        checks++;
        if (f_sid !== 1'b0 || s_sid !== 1'b0) begin
            errors++;
            $display("FAIL x0_stall got=%b%b want=00", f_sid, s_sid);
        end
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
        checks++;
        if ({f_fa, f_fb, f_bpa, f_bpb} !== 6'b0) begin
            errors++;
            $display("FAIL x0_fwd got=%b want=000000",
                     {f_fa, f_fb, f_bpa, f_bpb});
        end
    endtask

    task automatic test_redirect();
        do_reset();
        drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd6, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0);
        ex_redirect = 1'b1;
        #1;
        checks++;
        if ({f_fl, f_bub, f_sif, f_sid} !== 4'b1100) begin
            errors++;
            $display("FAIL redir_ctrl got=%b want=1100",
                     {f_fl, f_bub, f_sif, f_sid});
        end
        tick();
        ex_redirect = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (f_fcnt !== 32'd1 || f_scnt !== 32'd0) begin
            errors++;
            $display("FAIL redir_cnt got=%0d/%0d want=1/0", f_fcnt, f_scnt);
        end
        checks++;
        if (f_fl !== 1'b0) begin
            errors++;
            $display("FAIL redir_end got=%b want=0", f_fl);
        end
    endtask

    task automatic test_stall_mode();
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0);
        checks++;
        if ({s_sif, s_sid, s_bub} !== 3'b111) begin
            errors++;
            $display("FAIL m0_stall1 got=%b want=111", {s_sif, s_sid, s_bub});
        end
        tick();
        checks++;
        if ({s_sid, s_bpb} !== 2'b10) begin
            errors++;
            $display("FAIL m0_stall2 got=%b want=10", {s_sid, s_bpb});
        end
        tick();
        checks++;
        if ({s_sid, s_bpa, s_bpb} !== 3'b001) begin
            errors++;
            $display("FAIL m0_bypass got=%b want=001", {s_sid, s_bpa, s_bpb});
        end
        checks++;
        if (s_scnt !== 32'd2) begin
            errors++;
            $display("FAIL m0_scnt got=%0d want=2", s_scnt);
        end
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (s_fb !== 2'b00 || s_fa !== 2'b00) begin
            errors++;
            $display("FAIL m0_fwd got=%b/%b want=00/00", s_fa, s_fb);
        end
    endtask

    task automatic test_saturate_reset();
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        drive(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        tick();
        checks++;
        if (t_sid !== 1'b1 || t_scnt !== 2'd3) begin
            errors++;
            $display("FAIL sat_cnt got=%b/%0d want=1/3", t_sid, t_scnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({t_sif, t_sid, t_fl, t_bub, t_fa, t_fb, t_bpa, t_bpb,
             t_scnt, t_fcnt} !== '0) begin
            errors++;
            $display("FAIL rst_midstall got=%b want=0",
                     {t_sif, t_sid, t_fl, t_bub, t_fa, t_fb, t_bpa, t_bpb,
                      t_scnt, t_fcnt});
        end
    endtask

    initial begin
        rst = 1'b1;
        ex_redirect = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        test_reset();
        test_alu_chain();
        test_load_use();
        test_x0();
        test_redirect();
        test_stall_mode();
        test_saturate_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
